sbox_sched: RTL

SBOX_SCHED -- requirements
Module: sbox_sched

---
 rtl/sbox_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sbox_sched.sv
// sbox_sched: time-multiplexes four shared S-box lanes between a 128-bit
// round SubBytes requester (4 beats) and a 32-bit key SubWord requester
// (1 beat). Each beat is one ISSUE cycle (lanes enabled) followed by one
// CAPTURE cycle (lane results stored). Completed results are pulsed once
// and then held until the next job of the same type completes.
module sbox_sched #(
  parameter int ARB_MODE = 0  // 0: round-robin, 1: key has strict priority
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rnd_req_valid,
  input  logic [127:0] rnd_req_data,
  output logic         rnd_req_ready,
  output logic         rnd_resp_valid,
  output logic [127:0] rnd_resp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_data,
  output logic         key_resp_valid,
  output logic [31:0]  key_resp_data,
  output logic [31:0]  sb_in,
  output logic         sb_en,
  input  logic [31:0]  sb_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic KEY_PRIO = (ARB_MODE != 32'sd0);

  state_t       state_r, state_s;
  logic         job_key_r;       // 1 = current job is a key SubWord
  logic [127:0] job_data_r;      // latched request data
  logic [1:0]   beat_r;          // beat being processed
  logic         last_key_r;      // 1 = previous grant went to key
  logic [95:0]  rnd_acc_r;       // round beats 0..2 collected before commit
  logic [127:0] rnd_res_r;
  logic [31:0]  key_res_r;
  logic [31:0]  sb_in_r;
  logic         busy_r, sb_en_r, rnd_resp_valid_r, key_resp_valid_r;
  logic         grant_key_s, grant_rnd_s, last_beat_s;
  logic [1:0]   beat_next_s;

  // Arbitration: only in IDLE and out of reset; at most one grant.
  always_comb begin
    grant_key_s = 1'b0;
    grant_rnd_s = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      if (key_req_valid && rnd_req_valid) begin
        if (KEY_PRIO || !last_key_r) begin
          grant_key_s = 1'b1;
        end else begin
          grant_rnd_s = 1'b1;
        end
      end else if (key_req_valid) begin
        grant_key_s = 1'b1;
      end else if (rnd_req_valid) begin
        grant_rnd_s = 1'b1;
      end else begin
        grant_key_s = 1'b0;
        grant_rnd_s = 1'b0;
      end
    end else begin
      grant_key_s = 1'b0;
      grant_rnd_s = 1'b0;
    end
  end

  // Beat bookkeeping: a key job has one beat, a round job four.
  always_comb begin
    beat_next_s = beat_r + 2'd1;
    if (job_key_r) begin
      last_beat_s = 1'b1;
    end else begin
      last_beat_s = (beat_r == 2'd3);
    end
  end

  // Next-state logic for the IDLE/ISSUE/CAPTURE/DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_key_s || grant_rnd_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = CAPTURE;
      CAPTURE: begin
        if (last_beat_s) begin
          state_s = DONE;
        end else begin
          state_s = ISSUE;
        end
      end
      DONE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job latch, lane input word, beat counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_key_r  <= 1'b0;
      job_data_r <= 128'd0;
      beat_r     <= 2'd0;
      last_key_r <= 1'b1;
      rnd_acc_r  <= 96'd0;
      rnd_res_r  <= 128'd0;
      key_res_r  <= 32'd0;
      sb_in_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_key_s) begin
            job_key_r  <= 1'b1;
            job_data_r <= {96'd0, key_req_data};
            beat_r     <= 2'd0;
            sb_in_r    <= key_req_data;
            last_key_r <= 1'b1;
          end else if (grant_rnd_s) begin
            job_key_r  <= 1'b0;
            job_data_r <= rnd_req_data;
            beat_r     <= 2'd0;
            sb_in_r    <= rnd_req_data[31:0];
            last_key_r <= 1'b0;
          end
        end
        CAPTURE: begin
          if (job_key_r) begin
            key_res_r <= sb_out;
          end else begin
            // The round result is committed whole on the last beat so the
            // visible result never shows a partially updated state.
            case (beat_r)
              2'd0: rnd_acc_r[31:0]  <= sb_out;
              2'd1: rnd_acc_r[63:32] <= sb_out;
              2'd2: rnd_acc_r[95:64] <= sb_out;
              2'd3: rnd_res_r        <= {sb_out, rnd_acc_r};
              default: rnd_acc_r     <= rnd_acc_r;
            endcase
          end
          if (!last_beat_s) begin
            beat_r  <= beat_next_s;
            sb_in_r <= job_data_r[{beat_next_s, 5'd0} +: 32];
          end
        end
        default: begin
          beat_r <= beat_r;
        end
      endcase
    end
  end

  // Status and strobe outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r           <= 1'b0;
      sb_en_r          <= 1'b0;
      rnd_resp_valid_r <= 1'b0;
      key_resp_valid_r <= 1'b0;
    end else begin
      busy_r           <= (state_s != IDLE);
      sb_en_r          <= (state_s == ISSUE);
      rnd_resp_valid_r <= (state_s == DONE) && !job_key_r;
      key_resp_valid_r <= (state_s == DONE) && job_key_r;
    end
  end

  assign rnd_req_ready  = grant_rnd_s;
  assign key_req_ready  = grant_key_s;
  assign rnd_resp_valid = rnd_resp_valid_r;
  assign rnd_resp_data  = rnd_res_r;
  assign key_resp_valid = key_resp_valid_r;
  assign key_resp_data  = key_res_r;
  assign sb_in          = sb_in_r;
  assign sb_en          = sb_en_r;
  assign busy           = busy_r;

endmodule
